// File: rtl/shared_bus_scheduler.sv
// Round-robin scheduler time-sharing one bus among NREQ requesters with a held grant and one-cycle turnaround.
// Optional hold limit: define ARB_HOLD_LIMIT_EN to force a release after HOLD_MAX granted cycles.
module shared_bus_scheduler #(
    parameter int NREQ     = 4,
    parameter int HOLD_MAX = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         done,
    output logic [NREQ-1:0]         gnt,
    output logic                    gnt_valid,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    busy,
    output logic                    timeout_pulse
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic [NREQ-1:0] win_onehot;
    logic [ID_W-1:0] next_ptr;
    logic            rel_normal;

    // Rotating search: index wraps by subtraction so non-power-of-2 NREQ never overflows ID_W
    always_comb begin
        int              idx;
        logic [ID_W-1:0] idx_id;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        idx_id    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_id = ID_W'(idx);
            if (!win_found && req[idx_id]) begin
                win_found = 1'b1;
                win_id    = idx_id;
            end
        end
    end

    assign win_onehot = NREQ'(1) << win_id;
    assign next_ptr   = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    assign rel_normal = done[gnt_id] | ~req[gnt_id];

`ifdef ARB_HOLD_LIMIT_EN
    logic [CNT_W-1:0] cnt;
    logic             timeout_q;

    assign timeout_pulse = timeout_q;
`else
    assign timeout_pulse = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            busy      <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
            cnt       <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef ARB_HOLD_LIMIT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE, RELEASE: begin
                    if (win_found) begin
                        gnt       <= win_onehot;
                        gnt_id    <= win_id;
                        gnt_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= GRANT;
`ifdef ARB_HOLD_LIMIT_EN
                        cnt       <= CNT_W'(1);
`endif
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                GRANT: begin
`ifdef ARB_HOLD_LIMIT_EN
                    if (cnt != '1) cnt <= cnt + 1'b1;
`endif
                    if (rel_normal) begin
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        ptr       <= next_ptr;
                        state     <= RELEASE;
                    end
`ifdef ARB_HOLD_LIMIT_EN
                    // Forced release only when the owner is not already letting go
                    else if (cnt == CNT_W'(HOLD_MAX)) begin
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        ptr       <= next_ptr;
                        timeout_q <= 1'b1;
                        state     <= RELEASE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_bus_scheduler.sv
// Directed bench for shared_bus_scheduler (NREQ=4, HOLD_MAX=4); hold-limit checks follow ARB_HOLD_LIMIT_EN.
module tb_shared_bus_scheduler;

    logic       clk;
    logic       rstn;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    shared_bus_scheduler #(.NREQ(4), .HOLD_MAX(4)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req           (req),
        .done          (done),
        .gnt           (gnt),
        .gnt_valid     (gnt_valid),
        .gnt_id        (gnt_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] id, input logic b);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(|g));
        chk({tag, ".gnt_id"}, 32'(gnt_id), 32'(id));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    task automatic apply_reset(input logic [3:0] r);
        rstn = 1'b0;
        req  = r;
        done = '0;
        step();
        step();
        rstn = 1'b1;
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        rstn = 1'b0;
        req  = 4'b1111;
        done = '0;
        step();
        step();
        chk_out("rst", 4'b0000, 2'd0, 1'b0);
        chk("rst.timeout", 32'(timeout_pulse), 0);
        rstn = 1'b1;
        req  = '0;
        step();
        step();
        chk_out("idle", 4'b0000, 2'd0, 1'b0);

        // single requester, grant held until done
        req = 4'b0100;
        step();
        chk_out("single.c1", 4'b0100, 2'd2, 1'b1);
        repeat (3) step();
        chk_out("single.c4", 4'b0100, 2'd2, 1'b1);
        done = 4'b0100;
        step();
        chk_out("single.rel", 4'b0000, 2'd2, 1'b1);
        done = '0;
        req  = '0;
        step();
        chk_out("single.idle", 4'b0000, 2'd2, 1'b0);

        // fairness with all requesting, ptr starts at 0
        apply_reset(4'b0000);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_out($sformatf("fair%0d.c1", k), 4'(1 << exp_order[k]), 2'(exp_order[k]), 1'b1);
            step();
            chk_out($sformatf("fair%0d.c2", k), 4'(1 << exp_order[k]), 2'(exp_order[k]), 1'b1);
            step();
            chk_out($sformatf("fair%0d.c3", k), 4'(1 << exp_order[k]), 2'(exp_order[k]), 1'b1);
            done = 4'(1 << exp_order[k]);
            step();
            chk_out($sformatf("fair%0d.gap", k), 4'b0000, 2'(exp_order[k]), 1'b1);
            done = '0;
        end
        req = '0;
        step();
        chk_out("fair.idle", 4'b0000, 2'd0, 1'b0);

        // ptr is now 1: stray done ignored, withdraw releases
        req = 4'b0011;
        step();
        chk_out("wd.g1", 4'b0010, 2'd1, 1'b1);
        done = 4'b0001;
        step();
        chk_out("wd.stray", 4'b0010, 2'd1, 1'b1);
        done = '0;
        req  = 4'b0001;
        step();
        chk_out("wd.rel", 4'b0000, 2'd1, 1'b1);
        step();
        chk_out("wd.g0", 4'b0001, 2'd0, 1'b1);
        req = '0;
        step();
        chk_out("wd.rel0", 4'b0000, 2'd0, 1'b1);
        done = 4'b0001;
        step();
        chk_out("wd.idle", 4'b0000, 2'd0, 1'b0);
        done = '0;

        // mid-grant async reset; ptr was 1, so req=1001 after reset must pick 0
        req = 4'b1000;
        step();
        chk_out("mr.g3", 4'b1000, 2'd3, 1'b1);
        #3;
        rstn = 1'b0;
        req  = 4'b1001;
        #1;
        chk_out("mr.async", 4'b0000, 2'd0, 1'b0);
        step();
        rstn = 1'b1;
        step();
        chk_out("mr.ptr0", 4'b0001, 2'd0, 1'b1);

        apply_reset(4'b0000);
        req = 4'b0001;
        step();
        chk_out("hl.c1", 4'b0001, 2'd0, 1'b1);
`ifdef ARB_HOLD_LIMIT_EN
        for (int c = 2; c <= 4; c++) begin
            step();
            chk_out($sformatf("hl.c%0d", c), 4'b0001, 2'd0, 1'b1);
            chk($sformatf("hl.c%0d.to", c), 32'(timeout_pulse), 0);
        end
        step();
        chk_out("hl.force", 4'b0000, 2'd0, 1'b1);
        chk("hl.force.to", 32'(timeout_pulse), 1);
        step();
        chk_out("hl.regrant", 4'b0001, 2'd0, 1'b1);
        chk("hl.regrant.to", 32'(timeout_pulse), 0);
        req = 4'b0011;
        repeat (3) step();
        chk_out("hl.c4b", 4'b0001, 2'd0, 1'b1);
        step();
        chk("hl.force2.to", 32'(timeout_pulse), 1);
        step();
        chk_out("hl.next1", 4'b0010, 2'd1, 1'b1);
        repeat (3) step();
        done = 4'b0010;
        step();
        chk_out("hl.coinc", 4'b0000, 2'd1, 1'b1);
        chk("hl.coinc.to", 32'(timeout_pulse), 0);
        done = '0;
        req  = '0;
        step();
        chk_out("hl.idle", 4'b0000, 2'd1, 1'b0);
`else
        for (int c = 2; c <= 9; c++) begin
            step();
            chk_out($sformatf("nl.c%0d", c), 4'b0001, 2'd0, 1'b1);
            chk($sformatf("nl.c%0d.to", c), 32'(timeout_pulse), 0);
        end
        req = '0;
        step();
        chk_out("nl.rel", 4'b0000, 2'd0, 1'b1);
        step();
        chk_out("nl.idle", 4'b0000, 2'd0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
